// File: rtl/kyber_pkg.sv
// Shared Kyber constants, butterfly op codes, NTT sequencer state encoding and pipeline stage types.
// Optional inverse-NTT support in ntt_ctrl/ntt_addr_gen is enabled with NTT_CTRL_INTT_EN.
package kyber_pkg;

  localparam int Q    = 3329;
  localparam int QINV = 62209;  // q^-1 mod 2^16
  localparam int N    = 256;
  localparam int LOGN = 8;

  typedef enum logic [1:0] {
    BF_CT    = 2'd0,
    BF_GS    = 2'd1,
    BF_SCALE = 2'd2
  } bf_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } ntt_state_e;

  typedef struct packed {
    logic   valid;
    bf_op_e op;
  } bf_stage_t;

  typedef struct packed {
    logic            en;
    logic [LOGN-1:0] addr_a;
    logic [LOGN-1:0] addr_b;
  } wr_stage_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// Registered butterfly address / twiddle index generator for one (layer, index) issue slot.
// Inverse schedule and SCALE pass are present only when NTT_CTRL_INTT_EN is defined.
module ntt_addr_gen
  import kyber_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic            scale_pass,
  input  logic [2:0]      layer,
  input  logic [6:0]      idx,
  output logic [LOGN-1:0] addr_a,
  output logic [LOGN-1:0] addr_b,
  output logic [6:0]      zeta_idx
);

  logic [2:0]      span_log;  // log2 of the butterfly distance (len)
  logic [3:0]      grp_shift;
  logic [LOGN-1:0] span;
  logic [LOGN-1:0] a_nxt;
  logic [LOGN-1:0] b_nxt;
  logic [6:0]      grp;
  logic [6:0]      z_nxt;

  always_comb begin
    // NOTE: every always_comb output is assigned a default first, so no path can infer a latch.
    span_log = 3'd7 - layer;
`ifdef NTT_CTRL_INTT_EN
    if (mode) span_log = layer + 3'd1;
`endif
    span      = 8'd1 << span_log;
    grp       = idx >> span_log;
    grp_shift = {1'b0, span_log} + 4'd1;
    a_nxt     = ({1'b0, grp} << grp_shift) | ({1'b0, idx} & (span - 8'd1));
    b_nxt     = a_nxt | span;
    z_nxt     = (7'd1 << layer) + grp;
`ifdef NTT_CTRL_INTT_EN
    if (mode) z_nxt = (7'd127 >> layer) - grp;
    if (scale_pass) begin
      a_nxt = {idx, 1'b0};
      b_nxt = {idx, 1'b1};
      z_nxt = '0;
    end
`endif
  end

`ifndef NTT_CTRL_INTT_EN
  logic unused_cfg;
  assign unused_cfg = mode ^ scale_pass;
`endif

  // Outputs read as zero whenever no issue is scheduled for the coming cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst || !en) begin
      addr_a   <= '0;
      addr_b   <= '0;
      zeta_idx <= '0;
    end else begin
      addr_a   <= a_nxt;
      addr_b   <= b_nxt;
      zeta_idx <= z_nxt;
    end
  end

endmodule

// File: rtl/ntt_ctrl.sv
// Kyber NTT sequencer: issues butterfly reads, delays write-backs by the datapath depth, drains between layers.
// Define NTT_CTRL_INTT_EN to enable the inverse schedule (mode = 1) with its final SCALE pass.
module ntt_ctrl
  import kyber_pkg::*;
#(
  parameter int RAM_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [6:0] zeta_idx,
  output logic       bf_valid,
  output logic [1:0] bf_op,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b
);

  localparam int PIPE = RAM_LAT + MUL_LAT;
  localparam int DW   = (PIPE > 1) ? $clog2(PIPE) : 1;

  ntt_state_e    state, state_nxt;
  logic [2:0]    layer, layer_nxt;
  logic [6:0]    idx, idx_nxt;
  logic [DW-1:0] drain, drain_nxt;
  logic          mode_q, mode_nxt, mode_eff;
  logic          last_layer, drain_end, scale_nxt;
  bf_op_e        issue_op;
  bf_stage_t     bf_pipe [RAM_LAT];
  wr_stage_t     wr_pipe [PIPE];

`ifdef NTT_CTRL_INTT_EN
  assign mode_eff = mode;
  always_comb begin
    issue_op = BF_CT;
    if (mode_q && layer == 3'd7) issue_op = BF_SCALE;
    else if (mode_q)             issue_op = BF_GS;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign mode_eff    = 1'b0;
  assign issue_op    = BF_CT;
`endif

  // The inverse transform adds the SCALE pass as layer 7.
  assign last_layer = (layer == (mode_q ? 3'd7 : 3'd6));
  assign drain_end  = (drain == DW'(PIPE - 1));
  assign scale_nxt  = mode_nxt && (layer_nxt == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (idx == 7'd127) state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = last_layer ? FIN : ISSUE;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == ISSUE) || (state == DRAIN);
    done  = (state == FIN);
    rd_en = (state == ISSUE);
  end

  // Counter next-values also steer the registered address generator one cycle ahead.
  always_comb begin
    layer_nxt = layer;
    idx_nxt   = idx;
    drain_nxt = drain;
    mode_nxt  = mode_q;
    case (state)
      IDLE: if (start) begin
        layer_nxt = '0;
        idx_nxt   = '0;
        drain_nxt = '0;
        mode_nxt  = mode_eff;
      end
      ISSUE: idx_nxt = idx + 7'd1;
      DRAIN: begin
        drain_nxt = drain_end ? '0 : drain + DW'(1);
        if (drain_end) layer_nxt = layer + 3'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      layer  <= '0;
      idx    <= '0;
      drain  <= '0;
      mode_q <= 1'b0;
    end else begin
      layer  <= layer_nxt;
      idx    <= idx_nxt;
      drain  <= drain_nxt;
      mode_q <= mode_nxt;
    end
  end

  ntt_addr_gen u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (state_nxt == ISSUE),
    .mode       (mode_nxt),
    .scale_pass (scale_nxt),
    .layer      (layer_nxt),
    .idx        (idx_nxt),
    .addr_a     (rd_addr_a),
    .addr_b     (rd_addr_b),
    .zeta_idx   (zeta_idx)
  );

  always_ff @(posedge clk) begin
    // NOTE: the delay lines are reset on purpose: in-flight write strobes must be squashed by rst.
    if (!rst) begin
      for (int i = 0; i < RAM_LAT; i++) bf_pipe[i] <= '0;
      for (int i = 0; i < PIPE; i++)    wr_pipe[i] <= '0;
    end else begin
      bf_pipe[0] <= '{valid: rd_en, op: (rd_en ? issue_op : BF_CT)};
      for (int i = 1; i < RAM_LAT; i++) bf_pipe[i] <= bf_pipe[i-1];
      wr_pipe[0] <= '{en: rd_en, addr_a: rd_addr_a, addr_b: rd_addr_b};
      for (int i = 1; i < PIPE; i++)    wr_pipe[i] <= wr_pipe[i-1];
    end
  end

  assign bf_valid  = bf_pipe[RAM_LAT-1].valid;
  assign bf_op     = bf_pipe[RAM_LAT-1].op;
  assign wr_en     = wr_pipe[PIPE-1].en;
  assign wr_addr_a = wr_pipe[PIPE-1].addr_a;
  assign wr_addr_b = wr_pipe[PIPE-1].addr_b;

endmodule

// File: doc/ntt_ctrl.md
# ntt_ctrl

Sequencer for the Kyber NTT over a 256-coefficient polynomial in a two-read/two-write coefficient RAM. It drives one butterfly datapath built from the pipelined modular multiplier and the modular add/sub units. Each cycle it issues the butterfly read addresses and the twiddle index, and delays the matching write-back addresses by the pipeline depth. Between layers it drains the pipeline so that read-after-write hazards cannot occur.

## Interface
- RAM_LAT, 1: coefficient RAM read latency in cycles.
- MUL_LAT, 2: multiplier latency from operands to result.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle pulse; sampled only in IDLE.
- mode  in  1  0 = forward NTT, 1 = inverse NTT (requires the macro in Configuration).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the transform is complete.
- rd_en  out  1  read strobe.
- rd_addr_a, rd_addr_b  out  8  butterfly operand addresses.
- zeta_idx  out  7  twiddle ROM index; valid with rd_en.
- bf_valid  out  1  rd_en delayed by RAM_LAT; operands are valid at the datapath.
- bf_op  out  2  0 = CT butterfly, 1 = GS butterfly, 2 = scale; aligned with bf_valid.
- wr_en  out  1  rd_en delayed by PIPE = RAM_LAT + MUL_LAT.
- wr_addr_a, wr_addr_b  out  8  rd addresses delayed by PIPE.

## Operation
- States: IDLE, ISSUE, DRAIN, FIN.
- IDLE -> ISSUE on start. ISSUE -> DRAIN after 128 issues. DRAIN -> ISSUE (next layer) or -> FIN after PIPE cycles. FIN -> IDLE after 1 cycle, with done=1.
- Counters: layer L (3 bits) and butterfly index c (0..127, 7 bits).
- Forward schedule, L = 0..6:
  - len = 128>>L; group g = c / len; off = c mod len.
  - rd_addr_a = 2·len·g + off; rd_addr_b = rd_addr_a + len.
  - zeta_idx = (1<<L) + g; bf_op = 0.
- Inverse schedule, L = 0..6:
  - len = 2<<L; addresses computed as in the forward schedule.
  - zeta_idx = (128>>L) − 1 − g; bf_op = 1.
  - Followed by an 8th pass, SCALE: rd_addr_a = 2c, rd_addr_b = 2c+1, bf_op = 2, zeta_idx = 0.
- All address arithmetic is modulo 256 and never wraps in a legal schedule.
- Delay lines: shift registers of depth RAM_LAT (bf_valid, bf_op) and PIPE (wr_en, wr_addr_*). Write addresses equal the read addresses issued PIPE cycles earlier.
- start while busy: ignored.
- mode is latched at start; changes during busy have no effect.
- rst low at any cycle: at the next edge the FSM goes to IDLE and all counters and delay lines clear. No write strobe occurs after reset, even for butterflies in flight. RAM contents are then undefined, and software restarts the transform.

## Timing
- Reset values: busy = done = rd_en = bf_valid = wr_en = 0; all address, zeta_idx and bf_op outputs = 0.
- start sampled at cycle 0 -> first rd_en at cycle 1; busy = 1 from cycle 1.
- Each pass takes 128 + PIPE cycles. The last write of a pass occurs in the last DRAIN cycle; the first read of the next pass is the following cycle.
- Forward transform: done at cycle 7·(128+PIPE)+1, i.e. 918 at the defaults. busy falls in the same cycle.
- Inverse transform: done at cycle 8·(128+PIPE)+1, i.e. 1049 at the defaults.
- A new start is accepted in the cycle after done.

## Configuration
- NTT_CTRL_INTT_EN defined: the inverse schedule and the SCALE pass are available, selected by mode.
- Not defined: mode is ignored and treated as 0; bf_op ∈ {0}; the inverse zeta and SCALE logic is not synthesized.

## Structure
- The shared kyber_pkg holds:
  - Q = 3329, QINV, N = 256, LOGN = 8.
  - bf_op encodings (BF_CT, BF_GS, BF_SCALE).
  - FSM state encoding.
- Sub-module ntt_addr_gen: registered computation of rd_addr_a, rd_addr_b and zeta_idx from (L, c, mode, scale_pass).
- The delay lines and FSM stay in ntt_ctrl.

## Test plan
- Reset: hold rst = 0 for 3 cycles with start = 1 -> all outputs 0; busy stays 0.
- Forward, defaults: start -> exactly 896 rd_en cycles.
  - Cycles 1–2 issue (0,128,ζ1) and (1,129,ζ1).
  - Layer 6 first issue (0,2,ζ64) at cycle 787; last issue (253,255,ζ127).
  - done at 918.
- Write alignment: for every rd_en at cycle t, wr_en is at t+3 with identical addresses. No rd_addr in a pass equals a pending wr_addr from the previous pass.
- start pulsed at cycles 0 and 50 -> only one transform runs; done still at 918, single pulse.
- rst = 0 at cycle 300 -> at cycle 301 busy = wr_en = rd_en = 0 and no further writes. A new start at 305 gives done at 305+918.
- With NTT_CTRL_INTT_EN, mode = 1:
  - First issue (0,2,ζ127).
  - Layer 6 issue (0,128,ζ1).
  - SCALE pass (0,1)…(254,255) with bf_op = 2.
  - done at 1049.
